// File: rtl/can_rx_crc_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : can_pkg
// Description : Shared types, field lengths and the CRC-15 step function for
//               the CAN receive CRC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package can_pkg;

    // Frame-tracking states of the receive sequencer
    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        ARB       = 3'd2,
        CTRL      = 3'd3,
        DATA      = 3'd4,
        CRC_RX    = 3'd5,
        DELIM     = 3'd6
    } state_t;

    localparam int ID_LEN  = 11;
    localparam int DLC_LEN = 4;
    localparam int CRC_LEN = 15;

    localparam logic [CRC_LEN-1:0] CAN_CRC_POLY = 15'h4599;
    localparam int                 STUFF_LIMIT  = 5;

    // One serial CRC-15 step: MSB-out LFSR with the CAN generator polynomial
    function automatic logic [CRC_LEN-1:0] crc15_step(input logic [CRC_LEN-1:0] crc,
                                                      input logic               din);
        logic fb;
        fb         = din ^ crc[CRC_LEN-1];
        crc15_step = {crc[CRC_LEN-2:0], 1'b0} ^ (fb ? CAN_CRC_POLY : {CRC_LEN{1'b0}});
    endfunction

endpackage
`default_nettype wire

// File: rtl/can_rx_crc_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : can_rx_crc_controller_if
// Description : Bit-stream input and frame/CRC status outputs of the CAN
//               receive CRC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface can_rx_crc_controller_if;
    import can_pkg::*;

    logic                i_Bit;
    logic                i_Bit_Valid;
    logic                o_Busy;
    logic [ID_LEN-1:0]   o_ID;
    logic [DLC_LEN-1:0]  o_DLC;
    logic [7:0]          o_Data_Byte;
    logic                o_Byte_Valid;
    logic [CRC_LEN-1:0]  o_CRC;
    logic [CRC_LEN-1:0]  o_Rx_CRC;
    logic                o_Done;
    logic                o_CRC_OK;
    logic                o_CRC_Err;
    logic                o_Stuff_Err;
    logic                o_Form_Err;

    // Driver side: the sampling stage or a testbench
    modport master (
        output i_Bit, i_Bit_Valid,
        input  o_Busy, o_ID, o_DLC, o_Data_Byte, o_Byte_Valid, o_CRC, o_Rx_CRC,
               o_Done, o_CRC_OK, o_CRC_Err, o_Stuff_Err, o_Form_Err
    );

    // Sequencer side
    modport slave (
        input  i_Bit, i_Bit_Valid,
        output o_Busy, o_ID, o_DLC, o_Data_Byte, o_Byte_Valid, o_CRC, o_Rx_CRC,
               o_Done, o_CRC_OK, o_CRC_Err, o_Stuff_Err, o_Form_Err
    );
endinterface
`default_nettype wire

// File: rtl/can_crc15_sync.sv
`default_nettype none
// ============================================================================
// Module      : can_crc15_sync
// Description : Synchronous serial CRC-15 engine. i_Clear zeroes the register;
//               with i_Enable in the same cycle the bit is folded into the
//               cleared value, so the first bit of a frame costs no cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module can_crc15_sync
    import can_pkg::*;
(
    input  wire                 i_Clk,
    input  wire                 i_Rst,
    input  wire                 i_Clear,
    input  wire                 i_Enable,
    input  wire                 i_Bit,
    output logic [CRC_LEN-1:0]  o_CRC
);

    logic [CRC_LEN-1:0] crc_q;
    logic [CRC_LEN-1:0] crc_d;

    // Next CRC value: clear and/or fold in one bit
    always_comb begin
        crc_d = crc_q;
        if (i_Enable) begin
            crc_d = crc15_step(i_Clear ? {CRC_LEN{1'b0}} : crc_q, i_Bit);
        end else if (i_Clear) begin
            crc_d = {CRC_LEN{1'b0}};
        end
    end

    // CRC register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            crc_q <= {CRC_LEN{1'b0}};
        end else begin
            crc_q <= crc_d;
        end
    end

    assign o_CRC = crc_q;

endmodule
`default_nettype wire

// File: rtl/can_rx_crc_controller.sv
`default_nettype none
// ============================================================================
// Module      : can_rx_crc_controller
// Description : Receive-side CAN sequencer for standard frames: destuffs the
//               sampled bit stream, tracks ID/control/data/CRC fields, feeds
//               the covered bits into the CRC-15 engine and reports the
//               comparison against the received CRC.
// Revision    : 1.0 - initial release
// ============================================================================
module can_rx_crc_controller
    import can_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 8,
    parameter int IDLE_BITS      = 11
)(
    input  wire                     i_Clk,
    input  wire                     i_Rst,
    can_rx_crc_controller_if.slave  bus
);

    localparam int BYTE_W = $clog2(MAX_DATA_BYTES + 1);
    localparam int IDLE_W = $clog2(IDLE_BITS + 1);

    state_t               state_q,      state_d;
    logic [3:0]           bit_cnt_q,    bit_cnt_d;
    logic [BYTE_W-1:0]    byte_cnt_q,   byte_cnt_d;
    logic [BYTE_W-1:0]    nbytes_q,     nbytes_d;
    logic [2:0]           run_cnt_q,    run_cnt_d;
    logic                 last_bit_q,   last_bit_d;
    logic [IDLE_W-1:0]    idle_cnt_q,   idle_cnt_d;
    logic                 rtr_q,        rtr_d;
    logic [6:0]           shift_q,      shift_d;
    logic [ID_LEN-1:0]    id_q,         id_d;
    logic [DLC_LEN-1:0]   dlc_q,        dlc_d;
    logic [7:0]           byte_q,       byte_d;
    logic                 byte_vld_q,   byte_vld_d;
    logic [CRC_LEN-1:0]   rx_crc_q,     rx_crc_d;
    logic                 done_q,       done_d;
    logic                 crc_ok_q,     crc_ok_d;
    logic                 crc_err_q,    crc_err_d;
    logic                 stuff_err_q,  stuff_err_d;
    logic                 form_err_q,   form_err_d;

    logic                 w_bit;
    logic                 w_in_frame;
    logic                 w_stuff_slot;
    logic [DLC_LEN-1:0]   w_dlc_new;
    logic [BYTE_W-1:0]    w_dlc_capped;
    logic                 w_crc_clear;
    logic                 w_crc_enable;
    logic [CRC_LEN-1:0]   w_crc;

    assign w_bit        = bus.i_Bit;
    assign w_in_frame   = (state_q == ARB) || (state_q == CTRL) ||
                          (state_q == DATA) || (state_q == CRC_RX);
    // After a run of STUFF_LIMIT equal bits the next bit carries no field data
    assign w_stuff_slot = w_in_frame && (run_cnt_q == 3'(STUFF_LIMIT));
    assign w_dlc_new    = {dlc_q[DLC_LEN-2:0], w_bit};
    assign w_dlc_capped = (int'(w_dlc_new) > MAX_DATA_BYTES) ? BYTE_W'(MAX_DATA_BYTES)
                                                             : BYTE_W'(w_dlc_new);

    // Destuffing, field tracking and next-state decode
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        nbytes_d     = nbytes_q;
        run_cnt_d    = run_cnt_q;
        last_bit_d   = last_bit_q;
        idle_cnt_d   = idle_cnt_q;
        rtr_d        = rtr_q;
        shift_d      = shift_q;
        id_d         = id_q;
        dlc_d        = dlc_q;
        byte_d       = byte_q;
        rx_crc_d     = rx_crc_q;
        crc_ok_d     = crc_ok_q;
        byte_vld_d   = 1'b0;
        done_d       = 1'b0;
        crc_err_d    = 1'b0;
        stuff_err_d  = 1'b0;
        form_err_d   = 1'b0;
        w_crc_clear  = 1'b0;
        w_crc_enable = 1'b0;

        if (bus.i_Bit_Valid && w_in_frame) begin
            if (w_stuff_slot) begin
                if (w_bit == last_bit_q) begin
                    stuff_err_d = 1'b1;
                    state_d     = WAIT_IDLE;
                end else begin
                    run_cnt_d  = 3'd1;
                    last_bit_d = w_bit;
                end
            end else begin
                run_cnt_d  = (w_bit == last_bit_q) ? run_cnt_q + 3'd1 : 3'd1;
                last_bit_d = w_bit;
            end
        end

        if (bus.i_Bit_Valid && !w_stuff_slot) begin
            case (state_q)
                WAIT_IDLE: begin
                    if (!w_bit) begin
                        idle_cnt_d = '0;
                    end else if (idle_cnt_q == IDLE_W'(IDLE_BITS - 1)) begin
                        idle_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (!w_bit) begin
                        w_crc_clear  = 1'b1;
                        w_crc_enable = 1'b1;
                        run_cnt_d    = 3'd1;
                        last_bit_d   = 1'b0;
                        bit_cnt_d    = 4'd0;
                        crc_ok_d     = 1'b0;
                        state_d      = ARB;
                    end
                end
                ARB: begin
                    w_crc_enable = 1'b1;
                    if (bit_cnt_q == 4'(ID_LEN)) begin
                        rtr_d     = w_bit;
                        bit_cnt_d = 4'd0;
                        state_d   = CTRL;
                    end else begin
                        id_d      = {id_q[ID_LEN-2:0], w_bit};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                CTRL: begin
                    w_crc_enable = 1'b1;
                    bit_cnt_d    = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd0 && w_bit) begin
                        // Extended-ID frames are not handled
                        form_err_d = 1'b1;
                        state_d    = WAIT_IDLE;
                    end else if (bit_cnt_q >= 4'd2) begin
                        dlc_d = w_dlc_new;
                    end
                    if (bit_cnt_q == 4'(DLC_LEN + 1)) begin
                        bit_cnt_d  = 4'd0;
                        byte_cnt_d = '0;
                        nbytes_d   = w_dlc_capped;
                        state_d    = (rtr_q || w_dlc_new == '0) ? CRC_RX : DATA;
                    end
                end
                DATA: begin
                    w_crc_enable = 1'b1;
                    shift_d      = {shift_q[5:0], w_bit};
                    bit_cnt_d    = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        byte_d     = {shift_q, w_bit};
                        byte_vld_d = 1'b1;
                        bit_cnt_d  = 4'd0;
                        byte_cnt_d = BYTE_W'(byte_cnt_q + 1'b1);
                        if (BYTE_W'(byte_cnt_q + 1'b1) == nbytes_q) begin
                            state_d = CRC_RX;
                        end
                    end
                end
                CRC_RX: begin
                    rx_crc_d  = {rx_crc_q[CRC_LEN-2:0], w_bit};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(CRC_LEN - 1)) begin
                        bit_cnt_d = 4'd0;
                        state_d   = DELIM;
                    end
                end
                DELIM: begin
                    if (w_bit) begin
                        done_d    = 1'b1;
                        crc_ok_d  = (w_crc == rx_crc_q);
                        crc_err_d = (w_crc != rx_crc_q);
                    end else begin
                        form_err_d = 1'b1;
                    end
                    state_d = WAIT_IDLE;
                end
                default: state_d = WAIT_IDLE;
            endcase
        end
    end

    // State and field registers; reset overrides any coincident bit strobe
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= WAIT_IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            nbytes_q    <= '0;
            run_cnt_q   <= '0;
            last_bit_q  <= 1'b0;
            idle_cnt_q  <= '0;
            rtr_q       <= 1'b0;
            shift_q     <= '0;
            id_q        <= '0;
            dlc_q       <= '0;
            byte_q      <= '0;
            byte_vld_q  <= 1'b0;
            rx_crc_q    <= '0;
            done_q      <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            stuff_err_q <= 1'b0;
            form_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            nbytes_q    <= nbytes_d;
            run_cnt_q   <= run_cnt_d;
            last_bit_q  <= last_bit_d;
            idle_cnt_q  <= idle_cnt_d;
            rtr_q       <= rtr_d;
            shift_q     <= shift_d;
            id_q        <= id_d;
            dlc_q       <= dlc_d;
            byte_q      <= byte_d;
            byte_vld_q  <= byte_vld_d;
            rx_crc_q    <= rx_crc_d;
            done_q      <= done_d;
            crc_ok_q    <= crc_ok_d;
            crc_err_q   <= crc_err_d;
            stuff_err_q <= stuff_err_d;
            form_err_q  <= form_err_d;
        end
    end

    can_crc15_sync u_crc (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Clear  (w_crc_clear),
        .i_Enable (w_crc_enable),
        .i_Bit    (w_bit),
        .o_CRC    (w_crc)
    );

    assign bus.o_Busy       = w_in_frame || (state_q == DELIM);
    assign bus.o_ID         = id_q;
    assign bus.o_DLC        = dlc_q;
    assign bus.o_Data_Byte  = byte_q;
    assign bus.o_Byte_Valid = byte_vld_q;
    assign bus.o_CRC        = w_crc;
    assign bus.o_Rx_CRC     = rx_crc_q;
    assign bus.o_Done       = done_q;
    assign bus.o_CRC_OK     = crc_ok_q;
    assign bus.o_CRC_Err    = crc_err_q;
    assign bus.o_Stuff_Err  = stuff_err_q;
    assign bus.o_Form_Err   = form_err_q;

endmodule
`default_nettype wire

// File: tb/tb_can_rx_crc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_can_rx_crc_controller
// Description : Directed self-checking bench for the CAN receive CRC
//               sequencer: frame builder with CRC model and bit stuffer,
//               pulse monitor and immediate-assertion checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_can_rx_crc_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    can_rx_crc_controller_if bus ();

    can_rx_crc_controller #(
        .MAX_DATA_BYTES (8),
        .IDLE_BITS      (11)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse monitor: every single-cycle pulse is seen exactly once here
    int         mon_done = 0, mon_crc_err = 0, mon_stuff = 0, mon_form = 0, mon_bytes = 0;
    logic [7:0] byte_log [0:255];
    always @(negedge clk) begin
        if (bus.o_Byte_Valid) begin
            byte_log[mon_bytes % 256] = bus.o_Data_Byte;
            mon_bytes = mon_bytes + 1;
        end
        if (bus.o_Done)      mon_done    = mon_done + 1;
        if (bus.o_CRC_Err)   mon_crc_err = mon_crc_err + 1;
        if (bus.o_Stuff_Err) mon_stuff   = mon_stuff + 1;
        if (bus.o_Form_Err)  mon_form    = mon_form + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic raw_q[$];
    logic tx_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {4'd0, bus.o_Busy, bus.o_ID, bus.o_DLC, bus.o_Data_Byte, bus.o_Byte_Valid,
                bus.o_CRC, bus.o_Rx_CRC, bus.o_Done, bus.o_CRC_OK, bus.o_CRC_Err,
                bus.o_Stuff_Err, bus.o_Form_Err};
    endfunction

    // One idle cycle, then a one-cycle strobe; returns just after the strobe edge
    task automatic send_bit(input logic b);
        @(posedge clk); #1;
        bus.i_Bit       = b;
        bus.i_Bit_Valid = 1'b1;
        @(posedge clk); #1;
        bus.i_Bit_Valid = 1'b0;
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    // Builds raw fields, computes CRC-15 (0x4599, init 0), stuffs SOF..CRC end
    task automatic build_frame(input logic [10:0] id, input logic rtr, input logic ide,
                               input logic [3:0] dlc, input logic [63:0] data,
                               input logic [14:0] crc_flip, input logic delim,
                               output logic [14:0] crc_exp);
        logic [14:0] crc;
        logic [14:0] crc_tx;
        logic        nxt;
        logic        last;
        int          nbytes;
        int          run;
        raw_q.delete();
        tx_q.delete();
        raw_q.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw_q.push_back(id[i]);
        raw_q.push_back(rtr);
        raw_q.push_back(ide);
        raw_q.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw_q.push_back(dlc[i]);
        nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < 8 * nbytes; i++) raw_q.push_back(data[63-i]);
        crc = 15'd0;
        for (int i = 0; i < raw_q.size(); i++) begin
            nxt = raw_q[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (nxt) crc = crc ^ 15'h4599;
        end
        crc_exp = crc;
        crc_tx  = crc ^ crc_flip;
        for (int i = 14; i >= 0; i--) raw_q.push_back(crc_tx[i]);
        run  = 0;
        last = 1'b1;
        for (int i = 0; i < raw_q.size(); i++) begin
            tx_q.push_back(raw_q[i]);
            if (i == 0 || raw_q[i] != last) run = 1;
            else run++;
            last = raw_q[i];
            if (run == 5 && i != raw_q.size() - 1) begin
                tx_q.push_back(~raw_q[i]);
                last = ~raw_q[i];
                run  = 1;
            end
        end
        tx_q.push_back(delim);
    endtask

    task automatic send_frame(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            send_bit(tx_q[i]);
            if (i == 0) begin
                check("busy_after_sof", bus.o_Busy, 1);
                check("crc_ok_cleared_at_sof", bus.o_CRC_OK, 0);
            end
        end
    endtask

    logic [14:0] crc_exp;
    int b_done, b_crc_err, b_stuff, b_form, b_bytes;

    task automatic snap();
        b_done = mon_done; b_crc_err = mon_crc_err; b_stuff = mon_stuff;
        b_form = mon_form; b_bytes = mon_bytes;
    endtask

    logic [63:0] dlc15_data;

    initial begin
        rst             = 1'b1;
        bus.i_Bit       = 1'b1;
        bus.i_Bit_Valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_zero", all_outs(), 64'd0);
        rst = 1'b0;

        // Fewer than 11 recessive bits after reset: SOF must be ignored
        send_idle(10);
        send_bit(1'b0);
        check("sof_before_idle_ignored", bus.o_Busy, 0);
        send_idle(11);

        // Frame 1: all-zero standard frame, CRC 0x0000
        build_frame(11'h000, 1'b0, 1'b0, 4'h0, 64'd0, 15'h0000, 1'b1, crc_exp);
        snap();
        send_frame(tx_q.size());
        check("f1_done", bus.o_Done, 1);
        check("f1_crc_ok", bus.o_CRC_OK, 1);
        check("f1_crc_err", bus.o_CRC_Err, 0);
        check("f1_crc", bus.o_CRC, 15'h0000);
        check("f1_rx_crc", bus.o_Rx_CRC, 15'h0000);
        check("f1_id", bus.o_ID, 11'h000);
        check("f1_busy_fell", bus.o_Busy, 0);
        check("f1_no_errors", (mon_stuff - b_stuff) + (mon_form - b_form), 0);
        @(posedge clk); #1;
        check("f1_done_single_cycle", bus.o_Done, 0);
        check("f1_crc_ok_holds", bus.o_CRC_OK, 1);

        // Frame 2: same frame with last CRC bit inverted
        send_idle(11);
        build_frame(11'h000, 1'b0, 1'b0, 4'h0, 64'd0, 15'h0001, 1'b1, crc_exp);
        snap();
        send_frame(tx_q.size());
        check("f2_done", bus.o_Done, 1);
        check("f2_crc_err", bus.o_CRC_Err, 1);
        check("f2_crc_ok", bus.o_CRC_OK, 0);
        check("f2_rx_crc", bus.o_Rx_CRC, 15'h0001);
        check("f2_crc", bus.o_CRC, 15'h0000);

        // Stuff violation: SOF plus five more dominant bits
        send_idle(11);
        snap();
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        check("stuff_not_yet", mon_stuff - b_stuff, 0);
        check("stuff_busy_before", bus.o_Busy, 1);
        send_bit(1'b0);
        check("stuff_err_pulse", bus.o_Stuff_Err, 1);
        check("stuff_busy_dropped", bus.o_Busy, 0);
        send_bit(1'b0);
        check("stuff_sof_ignored", bus.o_Busy, 0);
        send_idle(10);
        send_bit(1'b0);
        check("stuff_sof_ignored_10", bus.o_Busy, 0);
        check("stuff_no_done", mon_done - b_done, 0);

        // Frame 3: ID 0x123, DLC 2, data A5 0F
        send_idle(11);
        build_frame(11'h123, 1'b0, 1'b0, 4'd2, 64'hA50F_0000_0000_0000, 15'h0, 1'b1, crc_exp);
        snap();
        send_frame(tx_q.size());
        check("f3_done", bus.o_Done, 1);
        check("f3_crc_ok", bus.o_CRC_OK, 1);
        check("f3_id", bus.o_ID, 11'h123);
        check("f3_dlc", bus.o_DLC, 4'd2);
        check("f3_crc", bus.o_CRC, crc_exp);
        check("f3_rx_crc", bus.o_Rx_CRC, crc_exp);
        check("f3_byte_count", mon_bytes - b_bytes, 2);
        check("f3_byte0", byte_log[b_bytes % 256], 8'hA5);
        check("f3_byte1", byte_log[(b_bytes + 1) % 256], 8'h0F);

        // Frame 4: remote frame, DLC 4, no data field
        send_idle(11);
        build_frame(11'h5A3, 1'b1, 1'b0, 4'd4, 64'hFFFF_FFFF_0000_0000, 15'h0, 1'b1, crc_exp);
        snap();
        send_frame(tx_q.size());
        check("f4_done", bus.o_Done, 1);
        check("f4_crc_ok", bus.o_CRC_OK, 1);
        check("f4_dlc", bus.o_DLC, 4'd4);
        check("f4_no_bytes", mon_bytes - b_bytes, 0);

        // Frame 5: DLC 15 capped to 8 bytes
        send_idle(11);
        dlc15_data = 64'h0123_4567_89AB_CDEF;
        build_frame(11'h7F0, 1'b0, 1'b0, 4'd15, dlc15_data, 15'h0, 1'b1, crc_exp);
        snap();
        send_frame(tx_q.size());
        check("f5_done", bus.o_Done, 1);
        check("f5_crc_ok", bus.o_CRC_OK, 1);
        check("f5_dlc", bus.o_DLC, 4'd15);
        check("f5_byte_count", mon_bytes - b_bytes, 8);
        for (int i = 0; i < 8; i++)
            check("f5_byte", byte_log[(b_bytes + i) % 256], dlc15_data[63-8*i -: 8]);

        // IDE = 1: form error right after the IDE strobe
        send_idle(11);
        build_frame(11'h2AA, 1'b1, 1'b1, 4'd0, 64'd0, 15'h0, 1'b1, crc_exp);
        snap();
        send_frame(13);
        check("ide_no_form_yet", mon_form - b_form, 0);
        send_bit(tx_q[13]);
        check("ide_form_err", bus.o_Form_Err, 1);
        check("ide_busy_dropped", bus.o_Busy, 0);

        // Dominant delimiter: form error, no done
        send_idle(11);
        build_frame(11'h000, 1'b0, 1'b0, 4'h0, 64'd0, 15'h0, 1'b0, crc_exp);
        snap();
        send_frame(tx_q.size());
        check("delim_form_err", bus.o_Form_Err, 1);
        check("delim_no_done", mon_done - b_done, 0);
        check("delim_busy_dropped", bus.o_Busy, 0);

        // Reset coincident with a strobe in the middle of the data field
        send_idle(11);
        build_frame(11'h123, 1'b0, 1'b0, 4'd2, 64'hA50F_0000_0000_0000, 15'h0, 1'b1, crc_exp);
        send_frame(24);
        check("rst_busy_in_data", bus.o_Busy, 1);
        @(posedge clk); #1;
        bus.i_Bit       = tx_q[24];
        bus.i_Bit_Valid = 1'b1;
        rst             = 1'b1;
        @(posedge clk); #1;
        bus.i_Bit_Valid = 1'b0;
        rst             = 1'b0;
        check("rst_mid_data_zero", all_outs(), 64'd0);
        @(posedge clk); #1;
        check("rst_still_zero", all_outs(), 64'd0);
        send_idle(11);
        snap();
        send_frame(tx_q.size());
        check("post_rst_done", bus.o_Done, 1);
        check("post_rst_crc_ok", bus.o_CRC_OK, 1);
        check("post_rst_id", bus.o_ID, 11'h123);
        check("post_rst_byte_count", mon_bytes - b_bytes, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
